// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch buffer.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_t;

  localparam int unsigned MEM_WORD_BYTES = 4;
  localparam int unsigned MEM_DATA_WIDTH = 8 * MEM_WORD_BYTES;
  localparam logic        MEM_CMD_READ   = 1'b0;

endpackage

// File: rtl/fetch_buffer_if.sv
// Word-wide memory request/response bus between fetch and the memory model.
interface fetch_buffer_if #(
  parameter int unsigned ADDRESS_WIDTH = 32
);
  import fetch_pkg::*;

  logic [ADDRESS_WIDTH-1:0]  o_mem_address;
  logic                      o_mem_valid;
  logic                      o_mem_cmd;
  logic                      i_mem_ready;
  logic [MEM_DATA_WIDTH-1:0] i_mem_data;
  logic                      i_mem_res_valid;
  logic                      o_mem_res_ready;

  modport master (
    output o_mem_address, o_mem_valid, o_mem_cmd, o_mem_res_ready,
    input  i_mem_ready, i_mem_data, i_mem_res_valid
  );

  modport slave (
    input  o_mem_address, o_mem_valid, o_mem_cmd, o_mem_res_ready,
    output i_mem_ready, i_mem_data, i_mem_res_valid
  );

endinterface

// File: rtl/byte_queue.sv
// Byte queue: oldest byte at [7:0], consume shifts out, append lands at the tail.
// Bytes above count are always zero, so appends can be OR-ed in.
module byte_queue
  import fetch_pkg::*;
#(
  parameter  int unsigned BUF_BYTES = 16,
  localparam int unsigned CW        = $clog2(BUF_BYTES + 1),
  localparam int unsigned QW        = 8 * BUF_BYTES
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [CW-1:0]             consume,
  input  logic                      append,
  input  logic [MEM_DATA_WIDTH-1:0] append_data,
  input  logic [1:0]                append_skip,
  output logic [QW-1:0]             bytes,
  output logic [CW-1:0]             count,
  output logic [CW-1:0]             consumed_c
);

  logic [QW-1:0]             q_r;
  logic [QW-1:0]             q_n;
  logic [CW-1:0]             count_r;
  logic [CW-1:0]             count_n;
  logic [CW-1:0]             remain;
  logic [MEM_DATA_WIDTH-1:0] word_aligned;

  // Retire at most what is held
  always_comb begin
    consumed_c = (consume > count_r) ? count_r : consume;
  end

  // Remove consumed bytes first, then append the unskipped word bytes at the new tail
  always_comb begin
    q_n          = q_r;
    count_n      = count_r;
    remain       = count_r - consumed_c;
    word_aligned = append_data >> {append_skip, 3'b000};
    if (flush) begin
      q_n     = '0;
      count_n = '0;
    end else begin
      q_n     = q_r >> {consumed_c, 3'b000};
      count_n = remain;
      if (append) begin
        q_n     = q_n | (QW'(word_aligned) << {remain, 3'b000});
        count_n = remain + CW'(3'(MEM_WORD_BYTES) - 3'(append_skip));
      end
    end
  end

  // Queue storage
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r     <= '0;
      count_r <= '0;
    end else begin
      q_r     <= q_n;
      count_r <= count_n;
    end
  end

  assign bytes = q_r;
  assign count = count_r;

endmodule

// File: rtl/fetch_buffer.sv
// Instruction prefetch: sequential word reads assembled into a byte window for the decoder.
// Optional FETCH_STATS_EN adds appended/dropped response counters.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter  int unsigned              ADDRESS_WIDTH = 32,
  parameter  int unsigned              BUF_BYTES     = 16,
  parameter  logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0,
  localparam int unsigned              CW            = $clog2(BUF_BYTES + 1),
  localparam int unsigned              QW            = 8 * BUF_BYTES
) (
  input  logic                     clk,
  input  logic                     reset,
  fetch_buffer_if.master           mem,
  output logic [QW-1:0]            o_bytes,
  output logic [CW-1:0]            o_count,
  input  logic [CW-1:0]            i_consume,
  input  logic                     i_redirect,
  input  logic [ADDRESS_WIDTH-1:0] i_redirect_addr
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]              o_words_fetched,
  output logic [31:0]              o_words_dropped
`endif
);

  localparam int unsigned FW = CW + 1;

  fetch_state_t             state_r;
  fetch_state_t             state_n;
  logic [ADDRESS_WIDTH-1:0] addr_r;
  logic [ADDRESS_WIDTH-1:0] addr_n;
  logic [1:0]               skip_r;
  logic [1:0]               skip_n;
  logic                     discard_r;
  logic                     discard_n;
  logic                     valid_r;
  logic                     res_ready_r;
  logic                     req_hs;
  logic                     res_hs;
  logic                     q_flush;
  logic                     q_append;
  logic [CW-1:0]            q_count;
  logic [CW-1:0]            q_consumed;
  logic [FW-1:0]            free_space;

  assign req_hs     = valid_r && mem.i_mem_ready;
  assign res_hs     = res_ready_r && mem.i_mem_res_valid;
  assign free_space = FW'(BUF_BYTES) - FW'(q_count) + FW'(q_consumed);

  byte_queue #(.BUF_BYTES(BUF_BYTES)) u_queue (
    .clk         (clk),
    .reset       (reset),
    .flush       (q_flush),
    .consume     (i_consume),
    .append      (q_append),
    .append_data (mem.i_mem_data),
    .append_skip (skip_r),
    .bytes       (o_bytes),
    .count       (q_count),
    .consumed_c  (q_consumed)
  );

  // Next-state, fetch address, skip offset and discard tracking
  always_comb begin
    state_n   = state_r;
    addr_n    = addr_r;
    skip_n    = skip_r;
    discard_n = discard_r;
    q_flush   = 1'b0;
    q_append  = 1'b0;
    if (i_redirect) begin
      q_flush = 1'b1;
      addr_n  = {i_redirect_addr[ADDRESS_WIDTH-1:2], 2'b00};
      skip_n  = i_redirect_addr[1:0];
      case (state_r)
        WAIT: begin
          // A response in this very cycle is dropped and retires the old request
          if (res_hs) begin
            state_n   = REQ;
            discard_n = 1'b0;
          end else begin
            discard_n = 1'b1;
          end
        end
        REQ: begin
          if (req_hs) begin
            state_n   = WAIT;
            discard_n = 1'b1;
          end
        end
        default: state_n = REQ;
      endcase
    end else begin
      case (state_r)
        IDLE: begin
          if (free_space >= FW'(MEM_WORD_BYTES)) state_n = REQ;
        end
        REQ: begin
          if (req_hs) state_n = WAIT;
        end
        WAIT: begin
          if (res_hs) begin
            if (discard_r) begin
              discard_n = 1'b0;
              state_n   = REQ;
            end else begin
              q_append = 1'b1;
              addr_n   = addr_r + ADDRESS_WIDTH'(MEM_WORD_BYTES);
              skip_n   = 2'b00;
              state_n  = IDLE;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // State and registered handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      addr_r      <= {RESET_PC[ADDRESS_WIDTH-1:2], 2'b00};
      skip_r      <= RESET_PC[1:0];
      discard_r   <= 1'b0;
      valid_r     <= 1'b0;
      res_ready_r <= 1'b0;
    end else begin
      state_r     <= state_n;
      addr_r      <= addr_n;
      skip_r      <= skip_n;
      discard_r   <= discard_n;
      valid_r     <= (state_n == REQ);
      res_ready_r <= (state_n == WAIT);
    end
  end

  assign mem.o_mem_address   = addr_r;
  assign mem.o_mem_valid     = valid_r;
  assign mem.o_mem_res_ready = res_ready_r;
  assign mem.o_mem_cmd       = MEM_CMD_READ;
  assign o_count             = q_count;

`ifdef FETCH_STATS_EN
  logic [31:0] fetched_r;
  logic [31:0] dropped_r;

  // Count responses appended versus discarded; both wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      fetched_r <= '0;
      dropped_r <= '0;
    end else begin
      if (res_hs && !i_redirect && !discard_r) fetched_r <= fetched_r + 32'd1;
      if (res_hs && (i_redirect || discard_r)) dropped_r <= dropped_r + 32'd1;
    end
  end

  assign o_words_fetched = fetched_r;
  assign o_words_dropped = dropped_r;
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: directed scenarios then random traffic against a byte-stream model.
module tb_fetch_buffer;

  localparam int unsigned BUF  = 16;
  localparam int unsigned CW   = $clog2(BUF + 1);
  localparam int unsigned QW   = 8 * BUF;
  localparam logic [31:0] RPC  = 32'h0000_0100;

  logic            clk;
  logic            reset;
  logic [QW-1:0]   o_bytes;
  logic [CW-1:0]   o_count;
  logic [CW-1:0]   i_consume;
  logic            i_redirect;
  logic [31:0]     i_redirect_addr;
`ifdef FETCH_STATS_EN
  logic [31:0]     o_words_fetched;
  logic [31:0]     o_words_dropped;
`endif

  fetch_buffer_if #(.ADDRESS_WIDTH(32)) mem_bus ();

  fetch_buffer #(.ADDRESS_WIDTH(32), .BUF_BYTES(BUF), .RESET_PC(RPC)) dut (
    .clk             (clk),
    .reset           (reset),
    .mem             (mem_bus),
    .o_bytes         (o_bytes),
    .o_count         (o_count),
    .i_consume       (i_consume),
    .i_redirect      (i_redirect),
    .i_redirect_addr (i_redirect_addr)
`ifdef FETCH_STATS_EN
    ,
    .o_words_fetched (o_words_fetched),
    .o_words_dropped (o_words_dropped)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: expected byte stream held in the queue plus fetch bookkeeping
  logic [7:0]  mq[$];
  logic [31:0] m_next;
  logic [1:0]  m_skip;
  bit          m_out;
  bit          m_disc;
  logic [31:0] m_fetched;
  logic [31:0] m_dropped;
  int          gap;

  // Memory model
  bit          mem_pend;
  logic [31:0] mem_addr;
  int          mem_delay;
  int          dmin = 0;
  int          dmax = 0;
  int          rdy_pct = 100;
  bit          hold = 0;
  logic [31:0] req_log[$];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'h4433_2211;
      32'h0000_0104: return 32'h8877_6655;
      32'h0000_0200: return 32'hDDCC_BBAA;
      default:       return (a * 32'h9E37_79B1) ^ 32'h5A17_C3E5;
    endcase
  endfunction

  task automatic model_reset();
    mq.delete();
    m_next    = {RPC[31:2], 2'b00};
    m_skip    = RPC[1:0];
    m_out     = 1'b0;
    m_disc    = 1'b0;
    m_fetched = '0;
    m_dropped = '0;
    gap       = 0;
    mem_pend  = 1'b0;
    req_log.delete();
  endtask

  // One cycle: check outputs at the negedge, drive inputs, advance model and memory
  task automatic step(input int cons, input bit redir, input logic [31:0] raddr, input bit rst);
    logic [127:0] exp_win;
    logic [31:0]  word;
    bit           rv;
    bit           req_hs;
    bit           res_hs;
    int           c;

    exp_win = '0;
    foreach (mq[i]) exp_win[8*i +: 8] = mq[i];
    check_eq("count", 128'(o_count), 128'(mq.size()));
    check_eq("window", o_bytes, exp_win);
    check_eq("address", 128'(mem_bus.o_mem_address), 128'(m_next));
    check_eq("res_ready", 128'(mem_bus.o_mem_res_ready), 128'(m_out));
    check_eq("cmd", 128'(mem_bus.o_mem_cmd), 128'(0));
    if (mem_bus.o_mem_valid)
      check_eq("issue_ok", 128'(mq.size() <= BUF - 4 && !m_out), 128'(1));
    if (!mem_bus.o_mem_valid && !m_out && mq.size() <= BUF - 4) gap++;
    else gap = 0;
    if (gap > 0) check_eq("issue_gap", 128'(gap <= 1), 128'(1));
`ifdef FETCH_STATS_EN
    check_eq("fetched", 128'(o_words_fetched), 128'(m_fetched));
    check_eq("dropped", 128'(o_words_dropped), 128'(m_dropped));
`endif

    rv = mem_pend && mem_delay == 0 && !hold;
    mem_bus.i_mem_res_valid = rv;
    mem_bus.i_mem_data      = rv ? mem_word(mem_addr) : $urandom();
    mem_bus.i_mem_ready     = ($urandom_range(99) < rdy_pct);
    i_consume       = CW'(cons);
    i_redirect      = redir;
    i_redirect_addr = raddr;
    reset           = rst;
    req_hs = mem_bus.o_mem_valid && mem_bus.i_mem_ready;
    res_hs = rv && mem_bus.o_mem_res_ready;

    if (rst) begin
      model_reset();
    end else begin
      if (req_hs) req_log.push_back(mem_bus.o_mem_address);
      if (redir) begin
        mq.delete();
        m_next = {raddr[31:2], 2'b00};
        m_skip = raddr[1:0];
        if (res_hs) begin
          m_out  = 1'b0;
          m_disc = 1'b0;
          m_dropped++;
        end else if (req_hs) begin
          m_out  = 1'b1;
          m_disc = 1'b1;
        end else if (m_out) begin
          m_disc = 1'b1;
        end
      end else begin
        c = (cons > mq.size()) ? mq.size() : cons;
        repeat (c) void'(mq.pop_front());
        if (res_hs) begin
          m_out = 1'b0;
          if (m_disc) begin
            m_disc = 1'b0;
            m_dropped++;
          end else begin
            word = mem_word(m_next);
            for (int k = int'(m_skip); k < 4; k++) mq.push_back(word[8*k +: 8]);
            m_next = m_next + 32'd4;
            m_skip = 2'b00;
            m_fetched++;
          end
        end
        if (req_hs) m_out = 1'b1;
      end
      if (res_hs) mem_pend = 1'b0;
      else if (mem_pend && mem_delay > 0) mem_delay--;
      if (req_hs) begin
        mem_pend  = 1'b1;
        mem_addr  = mem_bus.o_mem_address;
        mem_delay = $urandom_range(dmax, dmin);
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int idx;
    int max_cnt;

    reset = 1'b1;
    i_consume = '0;
    i_redirect = 1'b0;
    i_redirect_addr = '0;
    mem_bus.i_mem_ready = 1'b0;
    mem_bus.i_mem_res_valid = 1'b0;
    mem_bus.i_mem_data = '0;
    repeat (2) @(negedge clk);
    model_reset();

    // Reset state
    check_eq("rst_valid", 128'(mem_bus.o_mem_valid), 128'(0));
    check_eq("rst_res_ready", 128'(mem_bus.o_mem_res_ready), 128'(0));
    check_eq("rst_count", 128'(o_count), 128'(0));
    check_eq("rst_bytes", o_bytes, 128'(0));
    check_eq("rst_addr", 128'(mem_bus.o_mem_address), 128'(32'h100));

    // Two words from RESET_PC, little-endian into the queue
    step(0, 0, 0, 0);
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      if (o_count == CW'(8)) ok = 1;
      else step(0, 0, 0, 0);
    end
    check_eq("t1_wait", 128'(ok), 128'(1));
    check_eq("t1_req0", 128'(req_log.size() > 0 ? req_log[0] : 32'hX), 128'(32'h100));
    check_eq("t1_req1", 128'(req_log.size() > 1 ? req_log[1] : 32'hX), 128'(32'h104));
    check_eq("t1_bytes", 128'(o_bytes[63:0]), 128'(64'h8877_6655_4433_2211));

    // Fill stops at four requests until room is made
    repeat (40) step(0, 0, 0, 0);
    check_eq("t2_reqs", 128'(req_log.size()), 128'(4));
    check_eq("t2_full", 128'(o_count), 128'(16));
    check_eq("t2_novalid", 128'(mem_bus.o_mem_valid), 128'(0));
    step(4, 0, 0, 0);
    check_eq("t2_refill", 128'(mem_bus.o_mem_valid), 128'(1));

    // Unaligned redirect keeps only the tail byte of the first word
    step(0, 1, 32'h203, 0);
    idx = req_log.size();
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      if (o_count != '0) ok = 1;
      else step(0, 0, 0, 0);
    end
    check_eq("t3_wait", 128'(ok), 128'(1));
    check_eq("t3_addr", 128'(req_log.size() > idx ? req_log[idx] : 32'hX), 128'(32'h200));
    check_eq("t3_count", 128'(o_count), 128'(1));
    check_eq("t3_byte0", 128'(o_bytes[7:0]), 128'(8'hDD));

    // Redirect while waiting on 0x104: that response is dropped
    dmin = 3; dmax = 3;
    do_reset();
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (o_count == CW'(4) && mem_bus.o_mem_res_ready) ok = 1;
      else step(0, 0, 0, 0);
    end
    check_eq("t4_wait", 128'(ok), 128'(1));
    step(0, 1, 32'h300, 0);
    idx = req_log.size();
    max_cnt = 0;
    for (int i = 0; i < 40 && req_log.size() <= idx; i++) begin
      if (int'(o_count) > max_cnt) max_cnt = int'(o_count);
      step(0, 0, 0, 0);
    end
    check_eq("t4_count", 128'(max_cnt), 128'(0));
    check_eq("t4_addr", 128'(req_log.size() > idx ? req_log[idx] : 32'hX), 128'(32'h300));
`ifdef FETCH_STATS_EN
    check_eq("t4_dropped", 128'(o_words_dropped), 128'(1));
`endif

    // Consume clamp and consume-plus-append in one cycle
    dmin = 0; dmax = 0;
    do_reset();
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      if (o_count == CW'(8)) ok = 1;
      else step(0, 0, 0, 0);
    end
    hold = 1;
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      if (mem_bus.o_mem_res_ready) ok = 1;
      else step(0, 0, 0, 0);
    end
    check_eq("t5_wait", 128'(ok), 128'(1));
    step(2, 0, 0, 0);
    check_eq("t5_six", 128'(o_count), 128'(6));
    hold = 0;
    step(2, 0, 0, 0);
    check_eq("t5_append", 128'(o_count), 128'(8));
    step(2, 0, 0, 0);
    step(9, 0, 0, 0);
    check_eq("t5_clamp", 128'(o_count), 128'(0));

    // Reset in the middle of a wait
    hold = 1;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (mem_bus.o_mem_res_ready) ok = 1;
      else step(0, 0, 0, 0);
    end
    check_eq("t6_wait", 128'(ok), 128'(1));
    step(0, 0, 0, 1);
    hold = 0;
    check_eq("t6_count", 128'(o_count), 128'(0));
    check_eq("t6_valid", 128'(mem_bus.o_mem_valid), 128'(0));
    check_eq("t6_res_ready", 128'(mem_bus.o_mem_res_ready), 128'(0));
    check_eq("t6_addr", 128'(mem_bus.o_mem_address), 128'(32'h100));

    // Random traffic
    rdy_pct = 60; dmin = 0; dmax = 3;
    for (int i = 0; i < 3000; i++) begin
      int          cons;
      bit          redir;
      bit          rst;
      logic [31:0] ra;
      cons  = ($urandom_range(3) == 0) ? 0 : int'($urandom_range(BUF + 3));
      redir = ($urandom_range(39) == 0);
      rst   = ($urandom_range(799) == 0);
      ra    = ($urandom_range(7) == 0) ? 32'hFFFF_FFF0 + $urandom_range(15) : $urandom();
      step(cons, redir, ra, rst);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Instruction prefetch stage between the word-wide memory model and the x86 decoder. It issues sequential 32-bit read requests over the memory valid/ready handshake and assembles the returned words, little-endian, into a byte queue. It presents a byte window to the decoder, which consumes a variable number of bytes per cycle. A redirect input restarts fetch at any byte address, including unaligned ones.

## Interface
- ADDRESS_WIDTH, 32, byte address width
- BUF_BYTES, 16, byte queue capacity; multiple of 4, ≥ 8
- RESET_PC, 0, fetch byte address after reset
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- o_mem_address  out  ADDRESS_WIDTH  word-aligned read address (bits [1:0] = 0)
- o_mem_valid  out  1  request valid
- o_mem_cmd  out  1  constant read (0)
- i_mem_ready  in  1  memory accepts request
- i_mem_data  in  32  response word
- i_mem_res_valid  in  1  response valid
- o_mem_res_ready  out  1  response accepted
- o_bytes  out  8*BUF_BYTES  queue window; byte 0 at [7:0] is the oldest
- o_count  out  $clog2(BUF_BYTES+1)  number of valid bytes in o_bytes
- i_consume  in  $clog2(BUF_BYTES+1)  bytes retired this cycle
- i_redirect  in  1  flush queue and restart fetch
- i_redirect_addr  in  ADDRESS_WIDTH  new byte fetch address

## Operation
- States:
  - IDLE: no request outstanding.
  - REQ: o_mem_valid=1.
  - WAIT: request accepted; o_mem_res_ready=1.
- IDLE→REQ when free space ≥ 4. Free space = BUF_BYTES − o_count + consumed-this-cycle.
- REQ→WAIT on o_mem_valid && i_mem_ready. o_mem_address and o_mem_valid are held stable while in REQ.
- WAIT→IDLE on i_mem_res_valid && o_mem_res_ready. Bytes are appended at queue tail and the fetch word address advances by 4.
- The first word after a redirect appends only bytes [addr[1:0]..3]. The skip offset then clears.
- Consume: i_consume > o_count is clamped to o_count. Consume and append in the same cycle: remove consumed bytes first, then append at the new count.
- Redirect: the queue empties next cycle and the fetch address becomes {i_redirect_addr[AW-1:2],2'b00}.
  - From IDLE or REQ without a handshake: go to REQ with the new address next cycle.
  - From WAIT, or a REQ handshake in the same cycle: set the discard flag. The pending response is accepted and dropped, then the block goes to REQ.
  - A response arriving in the same cycle as the redirect is dropped.
  - Consume during a redirect cycle is ignored.
- Address wraps modulo 2^ADDRESS_WIDTH.

## Timing
- Reset values:
  - o_mem_valid=0, o_mem_res_ready=0, o_count=0, o_bytes=0, o_mem_cmd=0.
  - o_mem_address=RESET_PC & ~3, skip=RESET_PC[1:0], state IDLE, discard=0.
- Reset takes priority over all other inputs, including mid-WAIT. The memory's own reset is expected to be applied concurrently.
- First REQ is one cycle after reset deasserts.
- Response accepted at edge N gives o_count updated at N+1.
- At most one request is outstanding.
- o_mem_res_ready is registered and asserted throughout WAIT. Space is reserved at issue, so a response is never refused.
- Back-to-back: WAIT→IDLE→REQ costs one idle cycle between requests.

## Configuration
- FETCH_STATS_EN:
  - Defined: adds outputs o_words_fetched[31:0] (responses appended) and o_words_dropped[31:0] (responses discarded). Both zero on reset and wrap on overflow.
  - Undefined: the ports and counters are absent.

## Structure
- Shared package fetch_pkg:
  - fetch_state_t enum (IDLE, REQ, WAIT)
  - MEM_WORD_BYTES=4
  - MEM_CMD_READ constant
- Sub-module byte_queue: shift-out/append register array of BUF_BYTES bytes, with count, consume clamp and append-with-skip. fetch_buffer holds the FSM, addressing and the discard logic.

## Test plan
- Reset with RESET_PC=0x100 and memory words 0x44332211, 0x88776655. Consume 0 → requests to 0x100 then 0x104; o_count=8; o_bytes[63:0]=0x8877665544332211.
- Fill with consume 0 and BUF_BYTES=16 → exactly 4 requests. No fifth o_mem_valid until i_consume≥4.
- Redirect to 0x203, word at 0x200 = 0xDDCCBBAA → address 0x200 issued; o_count=1; byte 0 = 0xDD.
- Redirect while in WAIT for 0x104, to 0x300 → 0x104 response accepted and dropped (o_count stays 0). Next request is 0x300. With FETCH_STATS_EN, o_words_dropped=1.
- o_count=6 with i_consume=9 → o_count=0 next cycle. Same cycle as a response of 4 bytes with o_count=6 and i_consume=2 → o_count=8.
- Reset asserted during WAIT → next cycle o_count=0, o_mem_valid=0, address back to RESET_PC & ~3.
